// File: rtl/obi_pkg.sv
// Shared OBI request/response types and arbiter constants for the peripheral subsystem.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  // Returned to the owning master when the peripheral never answers.
  localparam logic [31:0] TIMEOUT_RDATA = 32'hBADCAB1E;

  typedef enum logic [1:0] {
    ArbIdle,
    ArbWait,
    ArbDrain
  } arb_state_e;

endpackage

// File: rtl/periph_rr_sel.sv
// Combinational round-robin pick: first requester at or after the pointer, with wrap-around.
module periph_rr_sel #(
  parameter int unsigned NumMasters = 2
) (
  input  logic [NumMasters-1:0]         req_i,
  input  logic [$clog2(NumMasters)-1:0] ptr_i,
  output logic [$clog2(NumMasters)-1:0] idx_o,
  output logic                          valid_o
);

  localparam int unsigned IdxW = $clog2(NumMasters);

  int unsigned cand;
  logic [IdxW-1:0] candIdx;

  // Explicit compare-and-subtract wrap keeps non-power-of-two counts correct.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    candIdx = '0;
    for (int unsigned k = 0; k < NumMasters; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NumMasters) begin
        cand = cand - NumMasters;
      end
      candIdx = IdxW'(cand);
      if (!valid_o && req_i[candIdx]) begin
        valid_o = 1'b1;
        idx_o   = candIdx;
      end
    end
  end

endmodule

// File: rtl/periph_obi_arbiter.sv
// Round-robin OBI arbiter with a single outstanding transaction and a response watchdog.
module periph_obi_arbiter
  import obi_pkg::*;
#(
  parameter int unsigned NumMasters    = 2,
  parameter int unsigned TimeoutCycles = 1023
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  obi_req_t                      master_req_i [NumMasters],
  output obi_resp_t                     master_resp_o [NumMasters],
  output obi_req_t                      slave_req_o,
  input  obi_resp_t                     slave_resp_i,
  output logic                          busy_o,
  output logic                          timeout_o,
  output logic [$clog2(NumMasters)-1:0] timeout_master_o
);

  localparam int unsigned IdxW = $clog2(NumMasters);
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumMasters - 1);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] tmaster_q, tmaster_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, timeout_q;

  logic [NumMasters-1:0] reqVec;
  logic [IdxW-1:0]       selIdx;
  logic                  selValid;
  logic                  wdFire;

  always_comb begin
    reqVec = '0;
    for (int unsigned i = 0; i < NumMasters; i++) begin
      reqVec[i] = master_req_i[i].req;
    end
  end

  periph_rr_sel #(
    .NumMasters(NumMasters)
  ) u_rr_sel (
    .req_i  (reqVec),
    .ptr_i  (rr_q),
    .idx_o  (selIdx),
    .valid_o(selValid)
  );

  // A real rvalid arriving on the limit cycle takes priority over the watchdog.
  assign wdFire = (state_q == ArbWait) && (cnt_q == CntMax) && !slave_resp_i.rvalid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ArbIdle;
      rr_q      <= '0;
      owner_q   <= '0;
      tmaster_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      tmaster_q <= tmaster_d;
      cnt_q     <= cnt_d;
      busy_q    <= (state_d != ArbIdle);
      timeout_q <= wdFire;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    tmaster_d = tmaster_q;
    cnt_d     = cnt_q;
    case (state_q)
      ArbIdle: begin
        if (selValid && slave_resp_i.gnt) begin
          owner_d = selIdx;
          rr_d    = (selIdx == LastIdx) ? '0 : selIdx + 1'b1;
          cnt_d   = '0;
          state_d = ArbWait;
        end
      end
      ArbWait: begin
        if (slave_resp_i.rvalid) begin
          state_d = ArbIdle;
        end else if (wdFire) begin
          tmaster_d = owner_q;
          state_d   = ArbDrain;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ArbDrain: begin
        if (slave_resp_i.rvalid) begin
          state_d = ArbIdle;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  // Only the selected master sees gnt and only the owner sees rvalid/rdata.
  always_comb begin
    slave_req_o = '0;
    for (int unsigned i = 0; i < NumMasters; i++) begin
      master_resp_o[i] = '0;
    end
    case (state_q)
      ArbIdle: begin
        if (selValid) begin
          slave_req_o               = master_req_i[selIdx];
          slave_req_o.req           = 1'b1;
          master_resp_o[selIdx].gnt = slave_resp_i.gnt;
        end
      end
      ArbWait: begin
        if (slave_resp_i.rvalid) begin
          master_resp_o[owner_q].rvalid = 1'b1;
          master_resp_o[owner_q].rdata  = slave_resp_i.rdata;
        end else if (wdFire) begin
          master_resp_o[owner_q].rvalid = 1'b1;
          master_resp_o[owner_q].rdata  = TIMEOUT_RDATA;
        end
      end
      default: ;
    endcase
  end

  assign busy_o           = busy_q;
  assign timeout_o        = timeout_q;
  assign timeout_master_o = tmaster_q;

endmodule
